// File: rtl/msi_writer.sv
// msi_writer: turns rising edges on wired interrupt lines into single 32-bit
// writes of the source number (EIID) to the seteipnum register of the selected
// IMSIC interrupt file.
// Build option: MSI_WRITER_RETRY_EN -- a source whose MSI ends in SLVERR/DECERR
// is queued again instead of being dropped.
module msi_writer #(
   parameter int                   NumSources  = 32,
   parameter int                   NrIntpFiles = 2,
   parameter int                   FileIdxW    = (NrIntpFiles > 1) ? $clog2(NrIntpFiles) : 1,
   parameter int                   AddrWidth   = 64,
   parameter logic [AddrWidth-1:0] ImsicBase   = AddrWidth'(64'h2400_0000),
   parameter logic [AddrWidth-1:0] FileStride  = AddrWidth'(64'h1000)
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [NumSources-1:0]        irq_i,
   input  logic [NumSources-1:0]        enable_i,
   input  logic [NumSources*FileIdxW-1:0] target_file_i,
   output logic [AddrWidth-1:0]         aw_addr_o,
   output logic                         aw_valid_o,
   input  logic                         aw_ready_i,
   output logic [31:0]                  w_data_o,
   output logic [3:0]                   w_strb_o,
   output logic                         w_valid_o,
   input  logic                         w_ready_i,
   input  logic [1:0]                   b_resp_i,
   input  logic                         b_valid_i,
   output logic                         b_ready_o,
   output logic                         busy_o,
   output logic                         err_o
);

   localparam int SelW = (NumSources > 1) ? $clog2(NumSources) : 1;
   // line 0 is reserved and never raises an MSI
   localparam logic [NumSources-1:0] SrcMask = ~NumSources'(1);

   typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

   state_t                  state;
   logic [NumSources-1:0]   irq_q;
   logic [NumSources-1:0]   pending;
   logic [NumSources-1:0]   rise;
   logic [NumSources-1:0]   clr;
   logic [NumSources-1:0]   requeue;
   logic [SelW-1:0]         sel;
   logic [FileIdxW-1:0]     file;
   logic                    any;
   logic                    aw_hs, w_hs, b_hs, b_err;

   assign rise  = irq_i & ~irq_q & enable_i & SrcMask;
   assign any   = |pending;
   assign file  = target_file_i[sel*FileIdxW +: FileIdxW];
   assign aw_hs = aw_valid_o & aw_ready_i;
   assign w_hs  = w_valid_o & w_ready_i;
   assign b_hs  = b_valid_i & b_ready_o;
   // SLVERR (2'b10) and DECERR (2'b11) both have the upper bit set
   assign b_err = b_resp_i[1];
   assign w_strb_o = 4'hF;

   // selected source is removed from pending as it is latched
   assign clr = (state == IDLE && any) ? (NumSources'(1) << sel) : '0;

`ifdef MSI_WRITER_RETRY_EN
   // failed source goes back into pending; w_data_o still holds its index
   assign requeue = (state == RESP && b_hs && b_err) ?
                    (NumSources'(1) << w_data_o[SelW-1:0]) : '0;
`else
   assign requeue = '0;
`endif

   // fixed priority: lowest pending index wins
   always_comb begin
      sel = '0;
      for (int i = NumSources - 1; i >= 1; i--)
         if (pending[i]) sel = SelW'(i);
   end

   // edge history and pending set/clear; a set in the same cycle as the clear wins
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         irq_q   <= '0;
         pending <= '0;
      end else begin
         irq_q   <= irq_i;
         pending <= (pending & ~clr) | rise | requeue;
      end
   end

   // transaction FSM with registered bus outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= IDLE;
         aw_addr_o  <= '0;
         w_data_o   <= '0;
         aw_valid_o <= 1'b0;
         w_valid_o  <= 1'b0;
         b_ready_o  <= 1'b0;
         busy_o     <= 1'b0;
         err_o      <= 1'b0;
      end else begin
         err_o <= 1'b0;
         unique case (state)
            IDLE: begin
               if (any) begin
                  aw_addr_o  <= ImsicBase + AddrWidth'(file) * FileStride;
                  w_data_o   <= 32'(sel);
                  aw_valid_o <= 1'b1;
                  w_valid_o  <= 1'b1;
                  busy_o     <= 1'b1;
                  state      <= SEND;
               end
            end
            SEND: begin
               // each channel retires on its own; a low valid means already done
               if (aw_hs) aw_valid_o <= 1'b0;
               if (w_hs)  w_valid_o  <= 1'b0;
               if ((aw_hs || !aw_valid_o) && (w_hs || !w_valid_o)) begin
                  b_ready_o <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (b_hs) begin
                  b_ready_o <= 1'b0;
                  busy_o    <= 1'b0;
                  err_o     <= b_err;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_msi_writer.sv
// Directed bench for msi_writer: reset values, edge-to-write latency and
// addressing, priority order, independent AW/W handshakes, ignored sources,
// error responses (with or without MSI_WRITER_RETRY_EN) and mid-transfer reset.
module tb_msi_writer;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic [31:0] irq_i, enable_i, target_file_i;
   logic [63:0] aw_addr_o;
   logic        aw_valid_o, aw_ready_i;
   logic [31:0] w_data_o;
   logic [3:0]  w_strb_o;
   logic        w_valid_o, w_ready_i;
   logic [1:0]  b_resp_i;
   logic        b_valid_i, b_ready_o, busy_o, err_o;

   int n_cmp = 0;
   int n_bad = 0;

   msi_writer dut (
      .clk_i(clk), .rst_ni(rst_ni), .irq_i(irq_i), .enable_i(enable_i),
      .target_file_i(target_file_i),
      .aw_addr_o(aw_addr_o), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
      .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_valid_o(w_valid_o),
      .w_ready_i(w_ready_i), .b_resp_i(b_resp_i), .b_valid_i(b_valid_i),
      .b_ready_o(b_ready_o), .busy_o(busy_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   // stimulus helpers: bounded waits, sampled on the falling edge
   task automatic wait_aw(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (aw_valid_o) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic wait_bready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (b_ready_o) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic send_b(input logic [1:0] resp);
      b_resp_i  = resp;
      b_valid_i = 1'b1;
      @(negedge clk);
      b_valid_i = 1'b0;
      b_resp_i  = 2'b00;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      n_cmp++; if ({aw_valid_o, w_valid_o, b_ready_o, busy_o, err_o} !== 5'b0) begin
         n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {aw_valid_o, w_valid_o, b_ready_o, busy_o, err_o}); end
      n_cmp++; if (aw_addr_o !== 64'h0 || w_data_o !== 32'h0) begin
         n_bad++; $display("FAIL reset_data: got addr %h data %h want 0/0", aw_addr_o, w_data_o); end
      n_cmp++; if (w_strb_o !== 4'hF) begin
         n_bad++; $display("FAIL reset_strb: got %h want f", w_strb_o); end
      rst_ni = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single;
      bit ok;
      target_file_i[5] = 1'b1;
      irq_i[5] = 1'b1;
      @(negedge clk);
      n_cmp++; if (aw_valid_o !== 1'b0) begin
         n_bad++; $display("FAIL single_early: aw_valid got %b want 0", aw_valid_o); end
      @(negedge clk);
      n_cmp++; if ({aw_valid_o, w_valid_o, busy_o} !== 3'b111) begin
         n_bad++; $display("FAIL single_valid: got %b want 111", {aw_valid_o, w_valid_o, busy_o}); end
      n_cmp++; if (aw_addr_o !== 64'h2400_1000) begin
         n_bad++; $display("FAIL single_addr: got %h want 24001000", aw_addr_o); end
      n_cmp++; if (w_data_o !== 32'd5 || w_strb_o !== 4'hF) begin
         n_bad++; $display("FAIL single_data: got %h/%h want 5/f", w_data_o, w_strb_o); end
      @(negedge clk);
      n_cmp++; if ({aw_valid_o, w_valid_o, b_ready_o} !== 3'b001) begin
         n_bad++; $display("FAIL single_resp: got %b want 001", {aw_valid_o, w_valid_o, b_ready_o}); end
      send_b(2'b00);
      n_cmp++; if ({busy_o, b_ready_o, err_o} !== 3'b000) begin
         n_bad++; $display("FAIL single_done: got %b want 000", {busy_o, b_ready_o, err_o}); end
      irq_i[5] = 1'b0;
      target_file_i[5] = 1'b0;
      wait_aw(ok);
      n_cmp++; if (ok !== 1'b0) begin
         n_bad++; $display("FAIL single_extra: got extra MSI data %h want none", w_data_o); end
   endtask

   task automatic test_priority;
      bit ok;
      irq_i[3] = 1'b1;
      irq_i[9] = 1'b1;
      wait_aw(ok);
      n_cmp++; if (!ok || w_data_o !== 32'd3 || aw_addr_o !== 64'h2400_0000) begin
         n_bad++; $display("FAIL prio_first: got ok %b data %h addr %h want 1/3/24000000", ok, w_data_o, aw_addr_o); end
      @(negedge clk);
      wait_bready(ok);
      send_b(2'b00);
      wait_aw(ok);
      n_cmp++; if (!ok || w_data_o !== 32'd9 || aw_addr_o !== 64'h2400_0000) begin
         n_bad++; $display("FAIL prio_second: got ok %b data %h addr %h want 1/9/24000000", ok, w_data_o, aw_addr_o); end
      @(negedge clk);
      wait_bready(ok);
      send_b(2'b00);
      irq_i[3] = 1'b0;
      irq_i[9] = 1'b0;
      n_cmp++; if (busy_o !== 1'b0) begin
         n_bad++; $display("FAIL prio_idle: busy got %b want 0", busy_o); end
   endtask

   task automatic test_w_delay;
      bit ok;
      w_ready_i = 1'b0;
      irq_i[2] = 1'b1;
      wait_aw(ok);
      n_cmp++; if (!ok || w_valid_o !== 1'b1) begin
         n_bad++; $display("FAIL wdly_start: got ok %b w_valid %b want 1/1", ok, w_valid_o); end
      @(negedge clk);
      n_cmp++; if ({aw_valid_o, w_valid_o, b_ready_o} !== 3'b010 || w_data_o !== 32'd2) begin
         n_bad++; $display("FAIL wdly_hold1: got %b data %h want 010/2", {aw_valid_o, w_valid_o, b_ready_o}, w_data_o); end
      @(negedge clk);
      n_cmp++; if ({aw_valid_o, w_valid_o, b_ready_o} !== 3'b010 || w_data_o !== 32'd2) begin
         n_bad++; $display("FAIL wdly_hold2: got %b data %h want 010/2", {aw_valid_o, w_valid_o, b_ready_o}, w_data_o); end
      w_ready_i = 1'b1;
      @(negedge clk);
      n_cmp++; if ({aw_valid_o, w_valid_o, b_ready_o, busy_o} !== 4'b0011) begin
         n_bad++; $display("FAIL wdly_resp: got %b want 0011", {aw_valid_o, w_valid_o, b_ready_o, busy_o}); end
      send_b(2'b01);
      irq_i[2] = 1'b0;
      n_cmp++; if ({busy_o, err_o} !== 2'b00) begin
         n_bad++; $display("FAIL wdly_done: got %b want 00", {busy_o, err_o}); end
   endtask

   task automatic test_ignored;
      bit seen;
      seen = 1'b0;
      enable_i[7] = 1'b0;
      irq_i[0] = 1'b1;
      irq_i[7] = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (aw_valid_o || busy_o) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin
         n_bad++; $display("FAIL ignored: transaction seen %b want 0", seen); end
      irq_i[0] = 1'b0;
      irq_i[7] = 1'b0;
      enable_i[7] = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_decerr;
      bit ok, seen;
      irq_i[4] = 1'b1;
      wait_aw(ok);
      n_cmp++; if (!ok || w_data_o !== 32'd4) begin
         n_bad++; $display("FAIL err_send: got ok %b data %h want 1/4", ok, w_data_o); end
      @(negedge clk);
      wait_bready(ok);
      send_b(2'b11);
      n_cmp++; if ({err_o, busy_o} !== 2'b10) begin
         n_bad++; $display("FAIL err_pulse: got %b want 10", {err_o, busy_o}); end
      @(negedge clk);
      n_cmp++; if (err_o !== 1'b0) begin
         n_bad++; $display("FAIL err_once: err got %b want 0", err_o); end
`ifdef MSI_WRITER_RETRY_EN
      n_cmp++; if (aw_valid_o !== 1'b1 || w_data_o !== 32'd4) begin
         n_bad++; $display("FAIL err_retry: got valid %b data %h want 1/4", aw_valid_o, w_data_o); end
      @(negedge clk);
      wait_bready(ok);
      send_b(2'b00);
`endif
      seen = 1'b0;
      repeat (6) begin
         if (aw_valid_o || err_o) seen = 1'b1;
         @(negedge clk);
      end
      n_cmp++; if (seen !== 1'b0) begin
         n_bad++; $display("FAIL err_quiet: further activity %b want 0", seen); end
      irq_i[4] = 1'b0;
   endtask

   task automatic test_reset_mid;
      bit ok;
      int msis;
      irq_i[6] = 1'b1;
      wait_aw(ok);
      n_cmp++; if (!ok || w_data_o !== 32'd6) begin
         n_bad++; $display("FAIL rmid_send: got ok %b data %h want 1/6", ok, w_data_o); end
      rst_ni = 1'b0;
      #1;
      n_cmp++; if ({aw_valid_o, w_valid_o, b_ready_o, busy_o, err_o} !== 5'b0 || aw_addr_o !== 64'h0 || w_data_o !== 32'h0) begin
         n_bad++; $display("FAIL rmid_abort: got %b addr %h data %h want 00000/0/0", {aw_valid_o, w_valid_o, b_ready_o, busy_o, err_o}, aw_addr_o, w_data_o); end
      @(negedge clk);
      n_cmp++; if ({aw_valid_o, busy_o} !== 2'b00 || w_strb_o !== 4'hF) begin
         n_bad++; $display("FAIL rmid_hold: got %b strb %h want 00/f", {aw_valid_o, busy_o}, w_strb_o); end
      rst_ni = 1'b1;
      wait_aw(ok);
      n_cmp++; if (!ok || w_data_o !== 32'd6 || aw_addr_o !== 64'h2400_0000) begin
         n_bad++; $display("FAIL rmid_resend: got ok %b data %h addr %h want 1/6/24000000", ok, w_data_o, aw_addr_o); end
      @(negedge clk);
      wait_bready(ok);
      send_b(2'b00);
      msis = 0;
      repeat (10) begin
         if (aw_valid_o) msis++;
         @(negedge clk);
      end
      n_cmp++; if (msis !== 0) begin
         n_bad++; $display("FAIL rmid_once: extra MSIs %0d want 0", msis); end
      irq_i[6] = 1'b0;
   endtask

   initial begin
      rst_ni = 1'b0;
      irq_i = '0;
      enable_i = '1;
      target_file_i = '0;
      aw_ready_i = 1'b1;
      w_ready_i = 1'b1;
      b_valid_i = 1'b0;
      b_resp_i = 2'b00;
      test_reset();
      test_single();
      test_priority();
      test_w_delay();
      test_ignored();
      test_decerr();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
